cuckoo_lookup: RTL and testbench

Read-side companion to the two-table cuckoo hash insert engine. Accepts a key with a lookup or delete opcode and probes table 1 at i1, then table 2 at i2. Reports hit/miss with the table and slot where the key was found; on a delete hit, clears that slot's filled bit. Connects to the shared table storage through a 1-cycle-latency read port and a single-cycle write port.

---
 rtl/cuckoo_pkg.sv | 28 ++
 rtl/cuckoo_index.sv | 34 +++
 rtl/cuckoo_lookup.sv | 125 ++++++++++++
 tb/tb_cuckoo_lookup.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cuckoo_pkg.sv
// rtl/cuckoo_pkg.sv - shared constants and types for the cuckoo hash table paths
// Purpose: table geometry, request opcodes, lookup FSM states and table selects.
// Ports: none (package).
package cuckoo_pkg;

  localparam int KEY_W = 32;
  localparam int DEPTH = 20;
  localparam int IDX_W = 5;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_DELETE = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_C1,
    S_P2,
    S_C2,
    S_DEL,
    S_RSP
  } state_e;

  localparam logic TBL1 = 1'b0;
  localparam logic TBL2 = 1'b1;

endpackage

// File: rtl/cuckoo_index.sv
// rtl/cuckoo_index.sv - combinational slot hashes for both cuckoo tables
// Purpose: maps a key to its table-1 slot i1 and table-2 slot i2.
// Ports:
//   key  in   KEY_W  key to hash
//   i1   out  IDX_W  ((key mod DEPTH)^3) mod DEPTH
//   i2   out  IDX_W  (((key < 32) ? 2^key : 0) + key, truncated to KEY_W) mod DEPTH
module cuckoo_index #(
  parameter int KEY_W = 32,
  parameter int DEPTH = 20,
  parameter int IDX_W = 5
) (
  input  logic [KEY_W-1:0] key,
  output logic [IDX_W-1:0] i1,
  output logic [IDX_W-1:0] i2
);

  // Residue is below 2^IDX_W, so its cube always fits in 3*IDX_W bits.
  localparam int CW = 3 * IDX_W;

  logic [CW-1:0]    res;
  logic [CW-1:0]    cube;
  logic [KEY_W-1:0] pow_term;
  logic [KEY_W-1:0] sum;

  assign res  = CW'(key % KEY_W'(DEPTH));
  assign cube = res * res * res;
  assign i1   = IDX_W'(cube % CW'(DEPTH));

  // Power term only exists for small keys and wraps with the sum at KEY_W bits.
  assign pow_term = (key < KEY_W'(32)) ? (KEY_W'(1) << key[4:0]) : '0;
  assign sum      = pow_term + key;
  assign i2       = IDX_W'(sum % KEY_W'(DEPTH));

endmodule

// File: rtl/cuckoo_lookup.sv
// rtl/cuckoo_lookup.sv - two-table cuckoo hash lookup/delete engine
// Purpose: probes table 1 then table 2 for a key, reports hit/miss, clears the
//          filled bit of the matching slot on a delete hit.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready/req_op/req_key  request handshake, opcode and key
//   tbl_rd_en/sel/addr               table read port (data one cycle later)
//   tbl_rd_data/tbl_rd_filled        stored key and filled bit
//   tbl_clr_en/sel/addr              one-cycle filled-bit clear strobe
//   rsp_valid/rsp_ready              response handshake
//   rsp_hit/rsp_sel/rsp_idx          result: found flag, table and slot
module cuckoo_lookup #(
  parameter int KEY_W = 32,
  parameter int DEPTH = 20,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [KEY_W-1:0] req_key,
  output logic             tbl_rd_en,
  output logic             tbl_rd_sel,
  output logic [IDX_W-1:0] tbl_rd_addr,
  input  logic [KEY_W-1:0] tbl_rd_data,
  input  logic             tbl_rd_filled,
  output logic             tbl_clr_en,
  output logic             tbl_clr_sel,
  output logic [IDX_W-1:0] tbl_clr_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic             rsp_sel,
  output logic [IDX_W-1:0] rsp_idx
);

  import cuckoo_pkg::*;

  state_e           state;
  op_e              op_q;
  logic [KEY_W-1:0] key_q;
  logic [IDX_W-1:0] i1;
  logic [IDX_W-1:0] i2;
  logic             hit_q;
  logic             sel_q;
  logic [IDX_W-1:0] idx_q;
  logic             match;

  cuckoo_index #(
    .KEY_W (KEY_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_index (
    .key (key_q),
    .i1  (i1),
    .i2  (i2)
  );

  // The filled bit gates the compare so stale data in an emptied slot never hits.
  assign match = tbl_rd_filled && (tbl_rd_data == key_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= OP_LOOKUP;
      key_q <= '0;
      hit_q <= 1'b0;
      sel_q <= TBL1;
      idx_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            key_q <= req_key;
            op_q  <= op_e'(req_op);
            state <= S_P1;
          end
        end
        S_P1: state <= S_C1;
        S_C1: begin
          if (match) begin
            hit_q <= 1'b1;
            sel_q <= TBL1;
            idx_q <= i1;
            state <= (op_q == OP_DELETE) ? S_DEL : S_RSP;
          end else begin
            state <= S_P2;
          end
        end
        S_P2: state <= S_C2;
        S_C2: begin
          if (match) begin
            hit_q <= 1'b1;
            sel_q <= TBL2;
            idx_q <= i2;
            state <= (op_q == OP_DELETE) ? S_DEL : S_RSP;
          end else begin
            hit_q <= 1'b0;
            sel_q <= TBL1;
            idx_q <= '0;
            state <= S_RSP;
          end
        end
        S_DEL: state <= S_RSP;
        S_RSP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Port strobes are pure state decodes; addresses come from registered state.
  assign req_ready    = (state == S_IDLE);
  assign tbl_rd_en    = (state == S_P1) || (state == S_P2);
  assign tbl_rd_sel   = (state == S_P2);
  assign tbl_rd_addr  = (state == S_P1) ? i1 : (state == S_P2) ? i2 : '0;
  assign tbl_clr_en   = (state == S_DEL);
  assign tbl_clr_sel  = (state == S_DEL) ? sel_q : TBL1;
  assign tbl_clr_addr = (state == S_DEL) ? idx_q : '0;
  assign rsp_valid    = (state == S_RSP);
  assign rsp_hit      = hit_q;
  assign rsp_sel      = sel_q;
  assign rsp_idx      = idx_q;

endmodule

// File: tb/tb_cuckoo_lookup.sv
// tb/tb_cuckoo_lookup.sv - directed self-checking bench for cuckoo_lookup
module tb_cuckoo_lookup;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [31:0] req_key = '0;
  logic        tbl_rd_en;
  logic        tbl_rd_sel;
  logic [4:0]  tbl_rd_addr;
  logic [31:0] tbl_rd_data = '0;
  logic        tbl_rd_filled = 1'b0;
  logic        tbl_clr_en;
  logic        tbl_clr_sel;
  logic [4:0]  tbl_clr_addr;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_hit;
  logic        rsp_sel;
  logic [4:0]  rsp_idx;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Table model: preloaded contents plus cleared flags updated by clr strobes.
  logic [31:0] t_data [2][20];
  logic        t_fill [2][20];
  logic        cleared [2][20] = '{default: '{default: 1'b0}};
  int          rd_cnt = 0;
  int          clr_cnt = 0;
  int          both_cnt = 0;
  logic        rd_log_sel [16];
  logic [4:0]  rd_log_addr [16];
  logic        clr_last_sel = 1'b0;
  logic [4:0]  clr_last_addr = '0;

  cuckoo_lookup #(.KEY_W(32), .DEPTH(20), .IDX_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_key       (req_key),
    .tbl_rd_en     (tbl_rd_en),
    .tbl_rd_sel    (tbl_rd_sel),
    .tbl_rd_addr   (tbl_rd_addr),
    .tbl_rd_data   (tbl_rd_data),
    .tbl_rd_filled (tbl_rd_filled),
    .tbl_clr_en    (tbl_clr_en),
    .tbl_clr_sel   (tbl_clr_sel),
    .tbl_clr_addr  (tbl_clr_addr),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_hit       (rsp_hit),
    .rsp_sel       (rsp_sel),
    .rsp_idx       (rsp_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tbl_rd_en) begin
      tbl_rd_data   <= t_data[tbl_rd_sel][tbl_rd_addr];
      tbl_rd_filled <= t_fill[tbl_rd_sel][tbl_rd_addr] & ~cleared[tbl_rd_sel][tbl_rd_addr];
      rd_log_sel[rd_cnt % 16]  <= tbl_rd_sel;
      rd_log_addr[rd_cnt % 16] <= tbl_rd_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (tbl_clr_en) begin
      cleared[tbl_clr_sel][tbl_clr_addr] <= 1'b1;
      clr_last_sel  <= tbl_clr_sel;
      clr_last_addr <= tbl_clr_addr;
      clr_cnt <= clr_cnt + 1;
    end
    if (tbl_rd_en && tbl_clr_en) both_cnt <= both_cnt + 1;
  end

  task automatic preload();
    for (int t = 0; t < 2; t++) begin
      for (int s = 0; s < 20; s++) begin
        t_data[t][s] = '0;
        t_fill[t][s] = 1'b0;
      end
    end
    t_data[0][4]  = 14; t_fill[0][4]  = 1'b1;
    t_data[0][9]  = 89; t_fill[0][9]  = 1'b1;
    t_data[0][12] = 48; t_fill[0][12] = 1'b1;
    t_data[0][16] = 76; t_fill[0][16] = 1'b1;
    t_data[0][17] = 13; t_fill[0][17] = 1'b1;
    t_data[1][2]  = 82; t_fill[1][2]  = 1'b1;
    t_data[1][10] = 70; t_fill[1][10] = 1'b1;
    t_data[1][19] = 11; t_fill[1][19] = 1'b1;
    t_data[1][11] = 91; t_fill[1][11] = 1'b1;
    t_data[1][5]  = 13; t_fill[1][5]  = 1'b1;
  endtask

  // Issues one request; lat is the consumer capture edge of rsp_valid counted
  // from the accept edge (0 when the response never came).
  task automatic issue(input logic op, input logic [31:0] key, output int lat, output int rd_base);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    rd_base   = rd_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk);
      #1 if (rsp_valid) lat = n + 1;
    end
  endtask

  task automatic check_rsp(input string name, input int lat, input int exp_lat,
                           input logic hit, input logic sel, input logic [4:0] idx);
    total_cnt++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if ({rsp_hit, rsp_sel, rsp_idx} !== {hit, sel, idx})
      $display("FAIL %s rsp: got hit=%0b sel=%0b idx=%0d expected hit=%0b sel=%0b idx=%0d",
               name, rsp_hit, rsp_sel, rsp_idx, hit, sel, idx);
    else pass_cnt++;
  endtask

  task automatic finish_rsp(input string name);
    @(posedge clk);
    #1;
    total_cnt++;
    if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL %s release: got rsp_valid=%0b req_ready=%0b expected 0 1", name, rsp_valid, req_ready);
    else pass_cnt++;
  endtask

  task automatic check_reads(input string name, input int base, input int n,
                             input logic s0, input logic [4:0] a0, input logic s1, input logic [4:0] a1);
    total_cnt++;
    if (rd_cnt - base !== n) $display("FAIL %s read count: got %0d expected %0d", name, rd_cnt - base, n);
    else pass_cnt++;
    total_cnt++;
    if ({rd_log_sel[base % 16], rd_log_addr[base % 16]} !== {s0, a0})
      $display("FAIL %s first read: got (%0b,%0d) expected (%0b,%0d)", name,
               rd_log_sel[base % 16], rd_log_addr[base % 16], s0, a0);
    else pass_cnt++;
    if (n > 1) begin
      total_cnt++;
      if ({rd_log_sel[(base + 1) % 16], rd_log_addr[(base + 1) % 16]} !== {s1, a1})
        $display("FAIL %s second read: got (%0b,%0d) expected (%0b,%0d)", name,
                 rd_log_sel[(base + 1) % 16], rd_log_addr[(base + 1) % 16], s1, a1);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({rsp_valid, rsp_hit, rsp_sel, rsp_idx, tbl_rd_en, tbl_clr_en} !== 10'b0)
      $display("FAIL reset outputs during reset: got %b expected 0",
               {rsp_valid, rsp_hit, rsp_sel, rsp_idx, tbl_rd_en, tbl_clr_en});
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset req_ready: got %0b expected 1", req_ready);
    else pass_cnt++;
    total_cnt++;
    if ({tbl_rd_sel, tbl_rd_addr, tbl_clr_sel, tbl_clr_addr} !== 12'b0)
      $display("FAIL reset addr/sel: got %b expected 0", {tbl_rd_sel, tbl_rd_addr, tbl_clr_sel, tbl_clr_addr});
    else pass_cnt++;
  endtask

  task automatic test_t1_hit();
    int lat, base;
    issue(1'b0, 32'd89, lat, base);
    check_rsp("t1_hit", lat, 3, 1'b1, 1'b0, 5'd9);
    finish_rsp("t1_hit");
    check_reads("t1_hit", base, 1, 1'b0, 5'd9, 1'b0, 5'd0);
  endtask

  task automatic test_t2_hit();
    int lat, base;
    issue(1'b0, 32'd70, lat, base);
    check_rsp("t2_hit", lat, 5, 1'b1, 1'b1, 5'd10);
    finish_rsp("t2_hit");
    check_reads("t2_hit", base, 2, 1'b0, 5'd0, 1'b1, 5'd10);
  endtask

  task automatic test_miss();
    int lat, base;
    issue(1'b0, 32'd33, lat, base);
    check_rsp("miss", lat, 5, 1'b0, 1'b0, 5'd0);
    finish_rsp("miss");
    check_reads("miss", base, 2, 1'b0, 5'd17, 1'b1, 5'd13);
  endtask

  task automatic test_delete();
    int lat, base, cbase;
    cbase = clr_cnt;
    issue(1'b1, 32'd13, lat, base);
    check_rsp("delete", lat, 4, 1'b1, 1'b0, 5'd17);
    finish_rsp("delete");
    total_cnt++;
    if ({clr_cnt - cbase, clr_last_sel, clr_last_addr} !== {32'd1, 1'b0, 5'd17})
      $display("FAIL delete clr: got count=%0d at (%0b,%0d) expected 1 at (0,17)",
               clr_cnt - cbase, clr_last_sel, clr_last_addr);
    else pass_cnt++;
    issue(1'b0, 32'd13, lat, base);
    check_rsp("after_delete", lat, 5, 1'b1, 1'b1, 5'd5);
    finish_rsp("after_delete");
  endtask

  task automatic test_hold();
    int lat, base;
    rsp_ready = 1'b0;
    issue(1'b0, 32'd82, lat, base);
    check_rsp("hold", lat, 5, 1'b1, 1'b1, 5'd2);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if ({rsp_valid, rsp_hit, rsp_sel, rsp_idx, req_ready} !== {1'b1, 1'b1, 1'b1, 5'd2, 1'b0})
        $display("FAIL hold cycle %0d: got valid=%0b hit=%0b sel=%0b idx=%0d req_ready=%0b expected 1 1 1 2 0",
                 c, rsp_valid, rsp_hit, rsp_sel, rsp_idx, req_ready);
      else pass_cnt++;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    finish_rsp("hold");
  endtask

  task automatic test_reset_in_delete();
    int lat, base, cbase;
    cbase = clr_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_key   = 32'd14;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({rsp_valid, rsp_hit, rsp_sel, rsp_idx, tbl_rd_en, tbl_clr_en,
         tbl_rd_sel, tbl_rd_addr, tbl_clr_sel, tbl_clr_addr} !== 22'b0)
      $display("FAIL reset_in_delete outputs: got %b expected 0",
               {rsp_valid, rsp_hit, rsp_sel, rsp_idx, tbl_rd_en, tbl_clr_en,
                tbl_rd_sel, tbl_rd_addr, tbl_clr_sel, tbl_clr_addr});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({clr_cnt - cbase, req_ready} !== {32'd0, 1'b1})
      $display("FAIL reset_in_delete idle: got clr=%0d req_ready=%0b expected 0 1", clr_cnt - cbase, req_ready);
    else pass_cnt++;
    issue(1'b0, 32'd14, lat, base);
    check_rsp("after_reset_lookup", lat, 3, 1'b1, 1'b0, 5'd4);
    finish_rsp("after_reset_lookup");
  endtask

  initial begin
    preload();
    test_reset();
    test_t1_hit();
    test_t2_hit();
    test_miss();
    test_delete();
    test_hold();
    test_reset_in_delete();
    total_cnt++;
    if (both_cnt !== 0) $display("FAIL rd_clr_overlap: got %0d expected 0", both_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
